// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared state type and default parameters for the multi-channel watchdog
package wdt_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      COUNTING = 2'd1,
      EXPIRED  = 2'd2
   } wdt_state_t;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_PRESCALE_W  = 8;

   // Channel index width, never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wdt_multi_if.sv
// rtl/wdt_multi_if.sv - clk2-domain config write strobes feeding the watchdog block
interface wdt_multi_if
   import wdt_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int PRESCALE_W = DEF_PRESCALE_W
);
   localparam int CH_W = ch_idx_w(NUM_CH);

   logic [CH_W-1:0]       wr_ch;
   logic                  wden_valid;
   logic                  wden_data;
   logic                  wdlive_valid;
   logic                  wtocnt_valid;
   logic [CNT_W-1:0]      wtocnt_data;
   logic                  prescale_valid;
   logic [PRESCALE_W-1:0] prescale_data;

   modport master (
      output wr_ch, wden_valid, wden_data, wdlive_valid,
      output wtocnt_valid, wtocnt_data, prescale_valid, prescale_data
   );

   modport slave (
      input wr_ch, wden_valid, wden_data, wdlive_valid,
      input wtocnt_valid, wtocnt_data, prescale_valid, prescale_data
   );

endinterface

// File: rtl/wdt_channel.sv
// rtl/wdt_channel.sv - one watchdog: state, counter, threshold and sticky expired flag
module wdt_channel
   import wdt_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk2,
   input  logic             rst2,
   input  logic             tick,
   input  logic             en_wr,
   input  logic             en_val,
   input  logic             kick,
   input  logic             thr_wr,
   input  logic [CNT_W-1:0] thr_val,
   output logic             expired_o,
   output logic             active_o
);

   wdt_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] thr_q, thr_d;
   logic             expired_q, expired_d;
   logic             enable_req, disable_req, hit;

   assign enable_req  = en_wr & en_val;
   assign disable_req = en_wr & ~en_val;
   // >= so a threshold lowered under the running count still fires on the next tick.
   assign hit         = tick & (cnt_q >= thr_q);

   always_ff @(posedge clk2 or posedge rst2) begin
      if (rst2) begin
         state_q   <= DISABLED;
         cnt_q     <= '0;
         thr_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         thr_q     <= thr_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DISABLED: if (enable_req) state_d = COUNTING;
         COUNTING: begin
            if (disable_req)      state_d = DISABLED;
            else if (!kick && hit) state_d = EXPIRED;
         end
         EXPIRED: begin
            if (disable_req) state_d = DISABLED;
            else if (kick)   state_d = COUNTING;
         end
         default: state_d = DISABLED;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      thr_d     = thr_wr ? thr_val : thr_q;
      expired_d = (state_q == EXPIRED);
      expired_o = expired_q;
      active_o  = (state_q != DISABLED);
      unique case (state_q)
         DISABLED: cnt_d = '0;
         COUNTING: begin
            if (disable_req || kick) cnt_d = '0;
            else if (tick && !hit)   cnt_d = cnt_q + CNT_W'(1);
         end
         EXPIRED: if (disable_req || kick) cnt_d = '0;
         default: cnt_d = '0;
      endcase
   end

endmodule

// File: rtl/wdt_multi.sv
// rtl/wdt_multi.sv - NUM_CH watchdogs on clk2 with interrupts synchronised into clk
// Optional shared tick prescaler enabled by defining WDT_PRESCALE_EN.
module wdt_multi
   import wdt_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int PRESCALE_W  = DEF_PRESCALE_W
) (
   input  logic              clk2,
   input  logic              rst2,
   input  logic              clk,
   input  logic              rst,
   wdt_multi_if.slave        cfg,
   output logic [NUM_CH-1:0] wto_status,
   output logic [NUM_CH-1:0] wto_irq,
   output logic              wto_any
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic              tick;
   logic [NUM_CH-1:0] active;

`ifdef WDT_PRESCALE_EN
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRESCALE_W-1:0] pre_rld_q, pre_rld_d;

   always_ff @(posedge clk2 or posedge rst2) begin
      if (rst2) begin
         pre_cnt_q <= '0;
         pre_rld_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pre_rld_q <= pre_rld_d;
      end
   end

   // Parked at the reload value while idle so the first tick is a full period after enable.
   always_comb begin
      pre_rld_d = pre_rld_q;
      pre_cnt_d = pre_cnt_q;
      if (cfg.prescale_valid) begin
         pre_rld_d = cfg.prescale_data;
         pre_cnt_d = cfg.prescale_data;
      end else if (!(|active) || (pre_cnt_q == '0)) begin
         pre_cnt_d = pre_rld_q;
      end else begin
         pre_cnt_d = pre_cnt_q - PRESCALE_W'(1);
      end
   end

   assign tick = (pre_cnt_q == '0);
`else
   logic [PRESCALE_W+NUM_CH:0] unused_sink;
   assign unused_sink = {cfg.prescale_valid, cfg.prescale_data, active};
   assign tick        = 1'b1;
`endif

   // Out-of-range wr_ch matches no channel and is dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = (cfg.wr_ch == CH_W'(i));

      wdt_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk2      (clk2),
         .rst2      (rst2),
         .tick      (tick),
         .en_wr     (sel & cfg.wden_valid),
         .en_val    (cfg.wden_data),
         .kick      (sel & cfg.wdlive_valid),
         .thr_wr    (sel & cfg.wtocnt_valid),
         .thr_val   (cfg.wtocnt_data),
         .expired_o (wto_status[i]),
         .active_o  (active[i])
      );
   end

   logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic              wto_any_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         wto_any_q <= 1'b0;
      end else begin
         sync_q[0] <= wto_status;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         wto_any_q <= |sync_q[SYNC_STAGES-1];
      end
   end

   assign wto_irq = sync_q[SYNC_STAGES-1];
   assign wto_any = wto_any_q;

endmodule

// File: tb/tb_wdt_multi.sv
// tb/tb_wdt_multi.sv - self-checking bench for wdt_multi with a rule-level reference model
module tb_wdt_multi;

   localparam int NCH   = 5;
   localparam int CW    = 32;
   localparam int SS    = 2;
   localparam int PW    = 8;
   localparam int CHW   = $clog2(NCH);
   localparam int CHMAX = 1 << CHW;

   logic           clk2 = 1'b0;
   logic           clk  = 1'b0;
   logic           rst2 = 1'b1;
   logic           rst  = 1'b1;
   logic [NCH-1:0] wto_status;
   logic [NCH-1:0] wto_irq;
   logic           wto_any;

   int  total = 0;
   int  bad   = 0;
   time t_clk = 0;

   int              m_st  [NCH];
   longint unsigned m_cnt [NCH];
   longint unsigned m_thr [NCH];
   logic [NCH-1:0]  m_stat;

   wdt_multi_if #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE_W(PW)) ifc ();

   wdt_multi #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .SYNC_STAGES (SS),
      .PRESCALE_W  (PW)
   ) dut (
      .clk2       (clk2),
      .rst2       (rst2),
      .clk        (clk),
      .rst        (rst),
      .cfg        (ifc),
      .wto_status (wto_status),
      .wto_irq    (wto_irq),
      .wto_any    (wto_any)
   );

   always #5 clk2 = ~clk2;
   always #6 clk  = ~clk;
   always @(posedge clk) t_clk = $time;

   task automatic idle_inputs();
      ifc.wr_ch          = '0;
      ifc.wden_valid     = 1'b0;
      ifc.wden_data      = 1'b0;
      ifc.wdlive_valid   = 1'b0;
      ifc.wtocnt_valid   = 1'b0;
      ifc.wtocnt_data    = '0;
      ifc.prescale_valid = 1'b0;
      ifc.prescale_data  = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) begin
         m_st[i]  = 0;
         m_cnt[i] = 0;
         m_thr[i] = 0;
      end
      m_stat = '0;
   endtask

   // States: 0 disabled, 1 counting, 2 expired; tick every cycle.
   task automatic model_update(input int ch, input bit ev, input bit ed, input bit kk,
                               input bit tv, input logic [CW-1:0] td);
      for (int i = 0; i < NCH; i++) begin
         bit sel, en_w, dis_w, kick_w;
         sel    = (ch == i);
         en_w   = sel && ev && ed;
         dis_w  = sel && ev && !ed;
         kick_w = sel && kk;
         m_stat[i] = (m_st[i] == 2);
         case (m_st[i])
            0: if (en_w) begin m_st[i] = 1; m_cnt[i] = 0; end
            1: begin
               if (dis_w) begin m_st[i] = 0; m_cnt[i] = 0; end
               else if (kick_w) m_cnt[i] = 0;
               else if (m_cnt[i] >= m_thr[i]) m_st[i] = 2;
               else m_cnt[i] = m_cnt[i] + 1;
            end
            default: begin
               if (dis_w) begin m_st[i] = 0; m_cnt[i] = 0; end
               else if (kick_w) begin m_st[i] = 1; m_cnt[i] = 0; end
            end
         endcase
         if (sel && tv) m_thr[i] = td;
      end
   endtask

   task automatic step(input int ch, input bit ev, input bit ed, input bit kk,
                       input bit tv, input logic [CW-1:0] td);
      ifc.wr_ch        = CHW'(ch);
      ifc.wden_valid   = ev;
      ifc.wden_data    = ed;
      ifc.wdlive_valid = kk;
      ifc.wtocnt_valid = tv;
      ifc.wtocnt_data  = td;
      model_update(ch, ev, ed, kk, tv, td);
      @(posedge clk2);
      #2;
      idle_inputs();
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic wait_status(input int ch, input int limit, output int n);
      n = 0;
      do begin
         idle(1);
         n++;
      end while (wto_status[ch] !== 1'b1 && n < limit);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst2 = 1'b1;
      rst  = 1'b1;
      repeat (3) @(posedge clk2);
      #2;
      rst2 = 1'b0;
      rst  = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      rst2 = 1'b1;
      rst  = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk2);
      #2;
      total++; if (wto_status !== '0) begin bad++; $display("FAIL reset_status: got %b want 0", wto_status); end
      total++; if (wto_irq !== '0) begin bad++; $display("FAIL reset_irq: got %b want 0", wto_irq); end
      total++; if (wto_any !== 1'b0) begin bad++; $display("FAIL reset_any: got %b want 0", wto_any); end
      do_reset();
      idle(5);
      total++; if (wto_status !== '0) begin bad++; $display("FAIL reset_idle: got %b want 0", wto_status); end
   endtask

   task automatic test_expire_latency();
      int  n, k;
      time t_rise;
      do_reset();
      step(0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      wait_status(0, 30, n);
      total++; if (n !== 7) begin bad++; $display("FAIL expire_latency: got %0d cycles want 7", n); end
      total++; if (wto_status[NCH-1:1] !== '0) begin bad++; $display("FAIL expire_others: got %b want 0", wto_status[NCH-1:1]); end
      t_rise = $time - 2;
      k = (t_clk > t_rise) ? 1 : 0;
      while (wto_irq[0] !== 1'b1 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      total++; if (k !== SS) begin bad++; $display("FAIL irq_latency: got %0d clk edges want %0d", k, SS); end
      total++; if (wto_any !== 1'b0) begin bad++; $display("FAIL any_early: got %b want 0", wto_any); end
      @(posedge clk);
      #1;
      total++; if (wto_any !== 1'b1) begin bad++; $display("FAIL any_rise: got %b want 1", wto_any); end
      total++; if (wto_irq !== NCH'(1)) begin bad++; $display("FAIL irq_vector: got %b want %b", wto_irq, NCH'(1)); end
   endtask

   task automatic test_kick();
      int n;
      bit seen;
      do_reset();
      step(1, 1'b0, 1'b0, 1'b0, 1'b1, 10);
      step(1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step(1, 1'b0, 1'b0, (c % 8 == 7), 1'b0, 0);
         if (wto_status[1] !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL kick_hold: got expiry want none"); end
      wait_status(1, 30, n);
      total++; if (n !== 8) begin bad++; $display("FAIL kick_release: got %0d cycles want 8", n); end
   endtask

   task automatic test_disable_kick();
      int n;
      do_reset();
      step(2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      wait_status(2, 10, n);
      total++; if (n !== 2) begin bad++; $display("FAIL thr0_expire: got %0d cycles want 2", n); end
      step(2, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      total++; if (wto_status[2] !== 1'b1) begin bad++; $display("FAIL dis_kick_lag: got %b want 1", wto_status[2]); end
      idle(1);
      total++; if (wto_status[2] !== 1'b0) begin bad++; $display("FAIL dis_kick_clear: got %b want 0", wto_status[2]); end
      idle(6);
      total++; if (wto_status[2] !== 1'b0) begin bad++; $display("FAIL dis_kick_stays: got %b want 0", wto_status[2]); end
      step(2, 1'b1, 1'b1, 1'b0, 1'b1, 3);
      wait_status(2, 20, n);
      total++; if (n !== 5) begin bad++; $display("FAIL reenable_restart: got %0d cycles want 5", n); end
   endtask

   task automatic test_lower_thr();
      int n;
      do_reset();
      step(3, 1'b0, 1'b0, 1'b0, 1'b1, 100);
      step(3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      idle(20);
      step(3, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      total++; if (wto_status[3] !== 1'b0) begin bad++; $display("FAIL lower_w0: got %b want 0", wto_status[3]); end
      idle(1);
      total++; if (wto_status[3] !== 1'b0) begin bad++; $display("FAIL lower_w1: got %b want 0", wto_status[3]); end
      idle(1);
      total++; if (wto_status[3] !== 1'b1) begin bad++; $display("FAIL lower_w2: got %b want 1", wto_status[3]); end
      step(3, 1'b0, 1'b0, 1'b0, 1'b1, 200);
      idle(2);
      total++; if (wto_status[3] !== 1'b1) begin bad++; $display("FAIL thr_keeps_expired: got %b want 1", wto_status[3]); end
      step(3, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      step(3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      wait_status(3, 10, n);
      total++; if (n !== 2) begin bad++; $display("FAIL reenable_thr0: got %0d cycles want 2", n); end
   endtask

   task automatic test_max_thr();
      do_reset();
      step(4, 1'b0, 1'b0, 1'b0, 1'b1, '1);
      step(4, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      idle(60);
      total++; if (wto_status !== '0) begin bad++; $display("FAIL max_thr: got %b want 0", wto_status); end
   endtask

   task automatic test_bad_ch();
      do_reset();
      for (int c = NCH; c < CHMAX; c++) step(c, 1'b1, 1'b1, 1'b0, 1'b1, 0);
      idle(10);
      total++; if (wto_status !== '0) begin bad++; $display("FAIL bad_ch_enable: got %b want 0", wto_status); end
      for (int c = 0; c < NCH; c++) step(c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      idle(3);
      total++; if (wto_status !== '1) begin bad++; $display("FAIL all_expire: got %b want all ones", wto_status); end
      for (int c = NCH; c < CHMAX; c++) step(c, 1'b1, 1'b0, 1'b1, 1'b1, 50);
      idle(3);
      total++; if (wto_status !== '1) begin bad++; $display("FAIL bad_ch_disable: got %b want all ones", wto_status); end
   endtask

`ifdef WDT_PRESCALE_EN
   task automatic test_prescale();
      int n;
      do_reset();
      ifc.prescale_valid = 1'b1;
      ifc.prescale_data  = 8'd3;
      step(0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      wait_status(0, 40, n);
      total++; if (n !== 13) begin bad++; $display("FAIL prescale_expire: got %0d cycles want 13", n); end
   endtask
`endif

   task automatic test_rst_mid();
      int n, k;
      do_reset();
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(2, 1'b0, 1'b0, 1'b0, 1'b1, 1000);
      step(2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      wait_status(0, 10, n);
      k = 0;
      while (wto_irq[0] !== 1'b1 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      total++; if (wto_any !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got %b want 1", wto_any); end
      @(posedge clk2);
      #3;
      rst2 = 1'b1;
      #1;
      total++; if (wto_status !== '0) begin bad++; $display("FAIL rst_mid_status: got %b want 0", wto_status); end
      k = 0;
      while (wto_irq !== '0 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      total++; if (k > SS) begin bad++; $display("FAIL rst_mid_irq: got %0d clk edges want <= %0d", k, SS); end
      @(posedge clk);
      #1;
      total++; if (wto_any !== 1'b0) begin bad++; $display("FAIL rst_mid_any: got %b want 0", wto_any); end
      @(posedge clk2);
      #2;
      rst2 = 1'b0;
      model_clear();
      idle(8);
      total++; if (wto_status !== '0) begin bad++; $display("FAIL rst_mid_disabled: got %b want 0", wto_status); end
   endtask

   task automatic test_random();
      int ch;
      bit ev, ed, kk, tv;
      logic [CW-1:0] td;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         ch = $urandom_range(0, CHMAX - 1);
         ev = ($urandom_range(0, 7) == 0);
         ed = ($urandom_range(0, 3) != 0);
         kk = ($urandom_range(0, 5) == 0);
         tv = ($urandom_range(0, 5) == 0);
         td = CW'($urandom_range(0, 12));
         step(ch, ev, ed, kk, tv, td);
         total++;
         if (wto_status !== m_stat) begin
            bad++;
            $display("FAIL random cycle %0d: got %b want %b", c, wto_status, m_stat);
         end
      end
   endtask

   initial begin
      idle_inputs();
      model_clear();
      test_reset();
      test_expire_latency();
      test_kick();
      test_disable_kick();
      test_lower_thr();
      test_max_thr();
      test_bad_ch();
`ifdef WDT_PRESCALE_EN
      test_prescale();
`endif
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
